mem_cycle_sched: RTL and testbench

MEM_CYCLE_SCHED -- requirements
Module: mem_cycle_sched

---
 rtl/mem_cycle_pkg.sv | 27 ++
 rtl/mem_cycle_arb.sv | 29 ++
 rtl/mem_cycle_sched.sv | 164 ++++++++++++++++
 tb/tb_mem_cycle_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cycle_pkg.sv
// Shared definitions for the core-memory cycle scheduler: FSM states,
// digit/address widths, phase counter width and arbiter grant encoding.
`timescale 1ns/1ps
package mem_cycle_pkg;

  // Digit is F,C,8,4,2,1 (flag plus BCD-with-check bits)
  localparam int DIGIT_W = 6;
  localparam int ADDR_W  = 15;
  localparam int CNT_W   = 6;

  // Bit positions inside the one-hot arbiter grant vector
  localparam int GNT_CPU = 0;
  localparam int GNT_IO  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Phase counter reload value: the counter runs length-1 down to 0
  function automatic logic [CNT_W-1:0] phase_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/mem_cycle_arb.sv
// Two-way fair arbiter: a lone requester wins; on a tie the requester that
// was not served last wins. Grant is one-hot (bit GNT_CPU / GNT_IO).
`timescale 1ns/1ps
module mem_cycle_arb
  import mem_cycle_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_io_req,
  input  logic       i_last_io,
  output logic [1:0] o_grant
);

  // Combinational grant decision
  always_comb begin
    o_grant = 2'b00;
    if (i_cpu_req && i_io_req) begin
      if (i_last_io) begin
        o_grant[GNT_CPU] = 1'b1;
      end else begin
        o_grant[GNT_IO] = 1'b1;
      end
    end else if (i_cpu_req) begin
      o_grant[GNT_CPU] = 1'b1;
    end else if (i_io_req) begin
      o_grant[GNT_IO] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_cycle_sched.sv
// Core-memory cycle scheduler: arbitrates CPU and I/O requests, then runs a
// destructive READ phase followed by a WRITE/regenerate phase and a one-clock
// ACK. Optional feature macro: MEM_CYCLE_PARITY_EN adds the parity_err output
// (pulses with ack when the captured digit's C,8,4,2,1 bits hold an even
// number of ones).
`timescale 1ns/1ps
module mem_cycle_sched
  import mem_cycle_pkg::*;
#(
  parameter int READ_CYC  = 10,
  parameter int WRITE_CYC = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               io_req,
  input  logic               cpu_we,
  input  logic               io_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [ADDR_W-1:0]  io_addr,
  input  logic [DIGIT_W-1:0] cpu_wdata,
  input  logic [DIGIT_W-1:0] io_wdata,
  output logic               cpu_ack,
  output logic               io_ack,
  output logic [DIGIT_W-1:0] rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_drive,
  output logic               mem_wr_drive,
  output logic [DIGIT_W-1:0] mem_wdata,
  input  logic [DIGIT_W-1:0] mem_rdata,
  output logic               busy,
`ifdef MEM_CYCLE_PARITY_EN
  output logic               parity_err,
`endif
  output logic               grant_io
);

  localparam logic [CNT_W-1:0] READ_LOAD  = phase_load(READ_CYC);
  localparam logic [CNT_W-1:0] WRITE_LOAD = phase_load(WRITE_CYC);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_latch;
  logic               w_capture;
  logic [1:0]         w_grant;

  // Owner of the running cycle; it also serves as the "last served" bit,
  // since it keeps its value until the next cycle is latched.
  logic               r_owner_io;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DIGIT_W-1:0] r_wdata;
  logic [DIGIT_W-1:0] r_rdigit;

  mem_cycle_arb u_arb (
    .i_cpu_req (cpu_req),
    .i_io_req  (io_req),
    .i_last_io (r_owner_io),
    .o_grant   (w_grant)
  );

  // State and phase counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request latch and read-digit capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_io <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdigit   <= '0;
    end else begin
      if (w_latch) begin
        r_owner_io <= w_grant[GNT_IO];
        if (w_grant[GNT_IO]) begin
          r_we    <= io_we;
          r_addr  <= io_addr;
          r_wdata <= io_wdata;
        end else begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
      end
      if (w_capture) begin
        r_rdigit <= mem_rdata;
      end
    end
  end

  // Next-state, counter reload/decrement and registered-state decoded outputs
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    cpu_ack      = 1'b0;
    io_ack       = 1'b0;
    rdata        = '0;
    mem_addr     = '0;
    mem_rd_drive = 1'b0;
    mem_wr_drive = 1'b0;
    mem_wdata    = '0;
    busy         = (r_state != IDLE);
    grant_io     = (r_state != IDLE) && r_owner_io;

    case (r_state)
      IDLE: begin
        if (w_grant != 2'b00) begin
          w_latch      = 1'b1;
          w_state_next = READ;
          w_cnt_next   = READ_LOAD;
        end
      end
      READ: begin
        mem_rd_drive = 1'b1;
        mem_addr     = r_addr;
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_state_next = WRITE;
          w_cnt_next   = WRITE_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      WRITE: begin
        mem_wr_drive = 1'b1;
        mem_addr     = r_addr;
        mem_wdata    = r_we ? r_wdata : r_rdigit;
        if (r_cnt == '0) begin
          w_state_next = ACK;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ACK: begin
        cpu_ack      = ~r_owner_io;
        io_ack       = r_owner_io;
        rdata        = r_rdigit;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef MEM_CYCLE_PARITY_EN
  // Odd parity over C,8,4,2,1 is expected; an even count flags an error
  assign parity_err = (r_state == ACK) && !(^r_rdigit[4:0]);
`endif

endmodule

// File: tb/tb_mem_cycle_sched.sv
// Directed testbench for mem_cycle_sched (default 10/10 timing plus a 1/1
// instance). Parity checks are compiled only with MEM_CYCLE_PARITY_EN.
`timescale 1ns/1ps
module tb_mem_cycle_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, io_req = 1'b0;
  logic        cpu_we = 1'b0, io_we = 1'b0;
  logic [14:0] cpu_addr = '0, io_addr = '0;
  logic [5:0]  cpu_wdata = '0, io_wdata = '0;
  logic [5:0]  mem_rdata = '0;

  logic        m_cpu_ack, m_io_ack, m_rd, m_wr, m_busy, m_gio;
  logic [5:0]  m_rdata, m_wdata;
  logic [14:0] m_addr;
  logic        s_cpu_ack, s_io_ack, s_rd, s_wr, s_busy, s_gio;
  logic [5:0]  s_rdata, s_wdata;
  logic [14:0] s_addr;
`ifdef MEM_CYCLE_PARITY_EN
  logic        m_par, s_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // results of the last do_cycle
  int          res_ack_clk, res_rd_cnt, res_wr_cnt;
  logic [5:0]  res_wdata, res_rdata;
  logic        res_ack_io, res_addr_bad, res_gio_bad, res_both_bad, res_par;

  always #5 clk = ~clk;

  mem_cycle_sched #(.READ_CYC(10), .WRITE_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .io_req(io_req), .cpu_we(cpu_we), .io_we(io_we),
    .cpu_addr(cpu_addr), .io_addr(io_addr), .cpu_wdata(cpu_wdata), .io_wdata(io_wdata),
    .cpu_ack(m_cpu_ack), .io_ack(m_io_ack), .rdata(m_rdata),
    .mem_addr(m_addr), .mem_rd_drive(m_rd), .mem_wr_drive(m_wr),
    .mem_wdata(m_wdata), .mem_rdata(mem_rdata), .busy(m_busy),
`ifdef MEM_CYCLE_PARITY_EN
    .parity_err(m_par),
`endif
    .grant_io(m_gio)
  );

  mem_cycle_sched #(.READ_CYC(1), .WRITE_CYC(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .io_req(io_req), .cpu_we(cpu_we), .io_we(io_we),
    .cpu_addr(cpu_addr), .io_addr(io_addr), .cpu_wdata(cpu_wdata), .io_wdata(io_wdata),
    .cpu_ack(s_cpu_ack), .io_ack(s_io_ack), .rdata(s_rdata),
    .mem_addr(s_addr), .mem_rd_drive(s_rd), .mem_wr_drive(s_wr),
    .mem_wdata(s_wdata), .mem_rdata(mem_rdata), .busy(s_busy),
`ifdef MEM_CYCLE_PARITY_EN
    .parity_err(s_par),
`endif
    .grant_io(s_gio)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reset both instances, leaving the bench just after a negedge in IDLE
  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    io_req  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run one request from an IDLE clock (clock 1 = the clock the request is
  // first presented). Requester inputs are scrambled at clock 3 to show the
  // latched values are used; the request is dropped when ack is seen.
  task automatic do_cycle(input bit io, input bit we, input logic [14:0] addr,
                          input logic [5:0] wd, input logic [5:0] rd);
    int idx;
    mem_rdata = rd;
    if (io) begin
      io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    res_ack_clk = 0; res_rd_cnt = 0; res_wr_cnt = 0;
    res_wdata = '0; res_rdata = '0; res_ack_io = 1'b0; res_par = 1'b0;
    res_addr_bad = 1'b0; res_gio_bad = 1'b0; res_both_bad = 1'b0;
    idx = 1;
    while (res_ack_clk == 0 && idx < 100) begin
      @(negedge clk);
      idx++;
      if (idx == 3) begin
        if (io) begin
          io_we = ~we; io_addr = addr ^ 15'h7FFF; io_wdata = wd ^ 6'h3F;
        end else begin
          cpu_we = ~we; cpu_addr = addr ^ 15'h7FFF; cpu_wdata = wd ^ 6'h3F;
        end
      end
      if (m_rd) res_rd_cnt++;
      if (m_wr) begin
        res_wr_cnt++;
        res_wdata = m_wdata;
      end
      if (m_rd && m_wr) res_both_bad = 1'b1;
      if ((m_rd || m_wr) && m_addr != addr) res_addr_bad = 1'b1;
      if (m_busy && m_gio != io) res_gio_bad = 1'b1;
      if (m_cpu_ack || m_io_ack) begin
        res_ack_clk = idx;
        res_rdata   = m_rdata;
        res_ack_io  = m_io_ack;
        if (m_cpu_ack && m_io_ack) res_both_bad = 1'b1;
`ifdef MEM_CYCLE_PARITY_EN
        res_par = m_par;
`endif
        cpu_req = 1'b0;
        io_req  = 1'b0;
      end
    end
    $display("cycle %s we=%0d addr=0x%0h: ack@%0d rd=%0d wr=%0d wdata=0x%0h rdata=0x%0h",
             io ? "IO" : "CPU", we, addr, res_ack_clk, res_rd_cnt, res_wr_cnt, res_wdata, res_rdata);
  endtask

  initial begin
    logic seq [4];
    int   n_ack;
    int   idx;
    bit   gap_checked;
    int   after;

    // ---- reset state ----
    @(negedge clk);
    check("rst_busy",  m_busy, 1'b0);
    check("rst_drv",   {m_rd, m_wr}, 2'b00);
    check("rst_addr",  m_addr, 15'h0);
    check("rst_acks",  {m_cpu_ack, m_io_ack}, 2'b00);
    check("rst_rdata", m_rdata, 6'h0);
    check("rst_gio",   m_gio, 1'b0);
    rst_n = 1'b1;

    // ---- CPU read, 0x1234, mem_rdata 0x15 ----
    do_cycle(1'b0, 1'b0, 15'h1234, 6'h00, 6'h15);
    check("t1_ack_clk", res_ack_clk, 22);
    check("t1_rd_cnt",  res_rd_cnt, 10);
    check("t1_wr_cnt",  res_wr_cnt, 10);
    check("t1_wdata",   res_wdata, 6'h15);
    check("t1_rdata",   res_rdata, 6'h15);
    check("t1_owner",   res_ack_io, 1'b0);
    check("t1_addr_bad", res_addr_bad, 1'b0);
    check("t1_gio_bad", res_gio_bad, 1'b0);
    check("t1_both_bad", res_both_bad, 1'b0);

    // ---- IO write, addr 19999, wdata 0x07 (core holds 0x2A) ----
    @(negedge clk);
    do_cycle(1'b1, 1'b1, 15'd19999, 6'h07, 6'h2A);
    check("t2_ack_clk", res_ack_clk, 22);
    check("t2_wdata",   res_wdata, 6'h07);
    check("t2_owner",   res_ack_io, 1'b1);
    check("t2_rdata",   res_rdata, 6'h2A);
    check("t2_addr_bad", res_addr_bad, 1'b0);
    check("t2_gio_bad", res_gio_bad, 1'b0);

    // ---- both held continuously after reset: IO,CPU,IO,CPU ----
    apply_reset();
    mem_rdata = 6'h0A;
    cpu_we = 1'b0; cpu_addr = 15'd1;
    io_we  = 1'b0; io_addr  = 15'd2;
    cpu_req = 1'b1; io_req = 1'b1;
    n_ack = 0; idx = 0; gap_checked = 1'b0; after = 0;
    while (n_ack < 4 && idx < 200) begin
      @(negedge clk);
      idx++;
      if (after == 1) begin
        check("arb_idle_gap", m_busy, 1'b0);
        after = 2;
      end else if (after == 2) begin
        check("arb_next_read", m_rd, 1'b1);
        after = 0;
        gap_checked = 1'b1;
      end
      if (m_cpu_ack || m_io_ack) begin
        seq[n_ack] = m_io_ack;
        check("arb_gio_at_ack", m_gio, m_io_ack);
        n_ack++;
        if (!gap_checked) after = 1;
        if (n_ack == 4) begin
          cpu_req = 1'b0;
          io_req  = 1'b0;
        end
      end
    end
    check("arb_ack_count", n_ack, 4);
    if (n_ack == 4) begin
      check("arb_g0", seq[0], 1'b1);
      check("arb_g1", seq[1], 1'b0);
      check("arb_g2", seq[2], 1'b1);
      check("arb_g3", seq[3], 1'b0);
    end
    $display("arbitration: %0d acks observed", n_ack);

    // ---- reset at READ clock 5, then a normal CPU cycle ----
    @(negedge clk);
    @(negedge clk);
    mem_rdata = 6'h31;
    cpu_we = 1'b0; cpu_addr = 15'h0ABC;
    cpu_req = 1'b1;                       // clock 1
    repeat (5) @(negedge clk);            // clock 6 = READ clock 5
    check("mid_rd_before", m_rd, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_drv_rst",  {m_rd, m_wr}, 2'b00);
    check("mid_busy_rst", m_busy, 1'b0);
    check("mid_addr_rst", m_addr, 15'h0);
    n_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_cpu_ack || m_io_ack) n_ack++;
    end
    check("mid_no_ack", n_ack, 0);
    rst_n = 1'b1;                          // request still high: clock 1
    do_cycle(1'b0, 1'b0, 15'h0ABC, 6'h00, 6'h31);
    check("mid_ack_clk", res_ack_clk, 22);
    check("mid_rdata",   res_rdata, 6'h31);
    check("mid_wdata",   res_wdata, 6'h31);

`ifdef MEM_CYCLE_PARITY_EN
    // ---- parity on captured digit ----
    @(negedge clk);
    do_cycle(1'b0, 1'b0, 15'h0010, 6'h00, 6'h03);
    check("par_03", res_par, 1'b1);
    @(negedge clk);
    do_cycle(1'b0, 1'b0, 15'h0011, 6'h00, 6'h13);
    check("par_13", res_par, 1'b0);
`endif

    // ---- 1/1 instance: ack at clock 4, request dropped in WRITE ----
    apply_reset();
    mem_rdata = 6'h21;
    cpu_we = 1'b0; cpu_addr = 15'd5;
    cpu_req = 1'b1;                       // clock 1
    idx = 1; n_ack = 0; after = 0;
    while (n_ack == 0 && idx < 20) begin
      @(negedge clk);
      idx++;
      if (s_wr) begin
        after = idx;
        cpu_req = 1'b0;
      end
      if (s_cpu_ack) begin
        n_ack = idx;
        res_rdata = s_rdata;
      end
    end
    check("s_wr_clk",  after, 3);
    check("s_ack_clk", n_ack, 4);
    check("s_rdata",   res_rdata, 6'h21);
    $display("short cycle: wr@%0d ack@%0d rdata=0x%0h", after, n_ack, res_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
